// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants for the fetch-to-decode queue
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INST   = 32'h00000013;
    localparam logic [63:0] PMEM_START = 64'h0000_0000_8000_0000;

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - push (fetch) and pop (decode) signals of the fetch queue
interface fetch_queue_if #(
    parameter int CNT_W = 3
) ();
    logic             flush_i;
    logic             push_valid_i;
    logic [63:0]      pc_i;
    logic [31:0]      inst_i;
    logic             is_compressed_i;
    logic             push_ready_o;
    logic             full_o;
    logic             pop_ready_i;
    logic             valid_o;
    logic [63:0]      pc_o;
    logic [31:0]      inst_o;
    logic             is_compressed_o;
    logic [CNT_W-1:0] count_o;

    modport slave (
        input  flush_i, push_valid_i, pc_i, inst_i, is_compressed_i, pop_ready_i,
        output push_ready_o, full_o, valid_o, pc_o, inst_o, is_compressed_o, count_o
    );

    modport master (
        output flush_i, push_valid_i, pc_i, inst_i, is_compressed_i, pop_ready_i,
        input  push_ready_o, full_o, valid_o, pc_o, inst_o, is_compressed_o, count_o
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode FIFO with flush; same-cycle bypass under FETCH_QUEUE_BYPASS_EN
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.slave  fq
);
    localparam int PTR_W = $clog2(DEPTH);

    generate
        if (!depth_ok(DEPTH)) begin : g_bad_depth
            $error("fetch_queue DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [63:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic             comp_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic empty;
    logic push_fire;
    logic pop_fire;
    logic bypass;
    logic head_valid;
    logic wr_en;
    logic rd_en;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push_fire = fq.push_valid_i & ~full;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & push_fire & ~fq.flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign head_valid = ~empty | bypass;
    assign pop_fire   = fq.pop_ready_i & head_valid;

    // A bypassed entry consumed in the same cycle never touches storage or pointers.
    assign wr_en = push_fire & ~(bypass & fq.pop_ready_i);
    assign rd_en = pop_fire & ~bypass;

    assign fq.push_ready_o = ~full;
    assign fq.full_o       = full;
    assign fq.valid_o      = head_valid;
    assign fq.count_o      = count;

    always_comb begin
        fq.pc_o            = '0;
        fq.inst_o          = NOP_INST;
        fq.is_compressed_o = 1'b0;
        if (!empty) begin
            fq.pc_o            = pc_mem[rd_ptr];
            fq.inst_o          = inst_mem[rd_ptr];
            fq.is_compressed_o = comp_mem[rd_ptr];
        end else if (bypass) begin
            fq.pc_o            = fq.pc_i;
            fq.inst_o          = fq.inst_i;
            fq.is_compressed_o = fq.is_compressed_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || fq.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // Storage is never reset; the empty mask on the head outputs hides stale entries.
    always_ff @(posedge clock) begin
        if (wr_en && !fq.flush_i && !reset) begin
            pc_mem[wr_ptr]   <= fq.pc_i;
            inst_mem[wr_ptr] <= fq.inst_i;
            comp_mem[wr_ptr] <= fq.is_compressed_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue (honours FETCH_QUEUE_BYPASS_EN)
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        comp;
    } entry_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    fetch_queue_if #(.CNT_W(CNT_W)) fq ();

    fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .fq    (fq)
    );

    always #5 clock = ~clock;

    entry_t exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     armed = 0;
    bit     byp_consumed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks the registered state and the head against the model every cycle.
    always @(negedge clock) begin
        if (armed) begin
            entry_t head;
            bit     exp_valid;
            bit     bypass_now;
            exp_valid    = (exp_q.size() != 0);
            bypass_now   = 0;
            byp_consumed = 0;
            if (exp_valid) head = exp_q[0];
`ifdef FETCH_QUEUE_BYPASS_EN
            if (!exp_valid && fq.push_valid_i && !fq.flush_i) begin
                exp_valid  = 1;
                bypass_now = 1;
                head.pc    = fq.pc_i;
                head.inst  = fq.inst_i;
                head.comp  = fq.is_compressed_i;
            end
`endif
            chk("count", 64'(fq.count_o), 64'(exp_q.size()));
            chk("full", 64'(fq.full_o), 64'(exp_q.size() == DEPTH));
            chk("push_ready", 64'(fq.push_ready_o), 64'(exp_q.size() != DEPTH));
            chk("valid", 64'(fq.valid_o), 64'(exp_valid));
            if (exp_valid) begin
                chk("head_pc", fq.pc_o, head.pc);
                chk("head_inst", 64'(fq.inst_o), 64'(head.inst));
                chk("head_comp", 64'(fq.is_compressed_o), 64'(head.comp));
                if (fq.pop_ready_i) begin
                    if (bypass_now) byp_consumed = 1;
                    else void'(exp_q.pop_front());
                end
            end else begin
                chk("empty_pc", fq.pc_o, 64'd0);
                chk("empty_inst", 64'(fq.inst_o), 64'(NOP_INST));
                chk("empty_comp", 64'(fq.is_compressed_o), 64'd0);
            end
        end
    end

    // Driver: one clock cycle of stimulus; records accepted pushes after the monitor has run.
    task automatic step(input logic pv, input logic [63:0] pc, input logic [31:0] inst,
                        input logic comp, input logic pr, input logic fl, input logic rs);
        bit acc;
        entry_t e;
        acc = pv && !fl && !rs && (exp_q.size() < DEPTH);
        reset              = rs;
        fq.flush_i         = fl;
        fq.push_valid_i    = pv;
        fq.pc_i            = pc;
        fq.inst_i          = inst;
        fq.is_compressed_i = comp;
        fq.pop_ready_i     = pr;
        @(negedge clock);
        #1;
        if (rs || fl) begin
            exp_q.delete();
        end else if (acc && !byp_consumed) begin
            e.pc = pc; e.inst = inst; e.comp = comp;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] inst, input logic comp, input logic pr);
        step(1'b1, pc, inst, comp, pr, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic pr);
        step(1'b0, 64'd0, 32'd0, 1'b0, pr, 1'b0, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pc;
        pc = PMEM_START;
        step(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        armed = 1;

        // Fill to full, refuse a fifth push, drain in order to empty.
        push(pc,         32'h00100093, 1'b0, 1'b0);
        push(pc + 64'h4, 32'h00200113, 1'b0, 1'b0);
        push(pc + 64'h8, 32'h00300193, 1'b0, 1'b0);
        push(pc + 64'hA, 32'h00400213, 1'b1, 1'b0);
        push(pc + 64'hC, 32'h00500293, 1'b0, 1'b0);
        repeat (5) idle(1'b1);

        // Steady state at count 2 with pointer wrap.
        push(pc, 32'h11111111, 1'b0, 1'b0);
        push(pc + 64'h4, 32'h22222222, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            push(pc + 64'(8 + 4 * i), 32'h33330000 + 32'(i), i[0], 1'b1);
        repeat (3) idle(1'b1);

        // Flush at count 3 with simultaneous push and pop.
        for (int i = 0; i < 3; i++) push(pc + 64'(4 * i), 32'h44440000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 64'hDEAD_BEEF_0000_0000, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b0);

        // Reset while full and mid-stream.
        for (int i = 0; i < 4; i++) push(pc + 64'(4 * i), 32'h55550000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, pc + 64'h40, 32'h66666666, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b0);

        // Empty queue push with pop ready (bypass target when enabled).
        push(pc + 64'h10, 32'h00700393, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom, 1'($urandom),
                 (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
        end
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
